// File: rtl/counter_param_falling.sv
// Falling-edge up/down counter with clear, load, clamp-to-MAX and wrap/saturate.
// out/done update one falling edge after sampling; tc is combinational; never stalls.
module counter_param_falling #(
  parameter int WIDTH = 5,
  parameter int MAX   = 31,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_V = '0;

  logic [WIDTH-1:0] out_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] term_v;

  assign term_v = up_dn ? MAX_V : ZERO_V;
  assign tc     = (out == term_v);

  always_comb begin
    out_nxt  = out;
    done_nxt = 1'b0;
    if (clr) begin
      out_nxt = ZERO_V;
    end else if (load) begin
      out_nxt = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (out < MAX_V)  out_nxt = out + ONE_V;
        else if (!SAT)    out_nxt = ZERO_V;
      end else begin
        if (out > ZERO_V) out_nxt = out - ONE_V;
        else if (!SAT)    out_nxt = MAX_V;
      end
      // A saturated hold leaves out unchanged, so it cannot re-fire done.
      done_nxt = (out_nxt == term_v) && (out_nxt != out);
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      out  <= ZERO_V;
      done <= 1'b0;
    end else begin
      out  <= out_nxt;
      done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_counter_param_falling.sv
// Bench: three counter flavours driven in parallel, checked by a queue-based scoreboard.
module tb_counter_param_falling;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, clr = 1'b0, load = 1'b0, up_dn = 1'b1;
  logic [4:0] load_val = '0;
  logic [4:0] out0, out1, out2;
  logic       tc0, tc1, tc2, done0, done1, done2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0][4:0] o;
    logic [2:0]      d;
    logic [2:0]      t;
  } exp_t;

  exp_t q[$];
  int   cnt[3];

  always #5 clk = ~clk;

  counter_param_falling #(.WIDTH(5), .MAX(31), .SAT(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up_dn(up_dn), .out(out0), .tc(tc0), .done(done0));
  counter_param_falling #(.WIDTH(5), .MAX(9), .SAT(1'b1)) u1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up_dn(up_dn), .out(out1), .tc(tc1), .done(done1));
  counter_param_falling #(.WIDTH(5), .MAX(20), .SAT(1'b0)) u2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up_dn(up_dn), .out(out2), .tc(tc2), .done(done2));

  function automatic int mx(input int i);
    return (i == 0) ? 31 : (i == 1) ? 9 : 20;
  endfunction

  function automatic bit sat(input int i);
    return (i == 1);
  endfunction

  function automatic int get_out(input int i);
    return (i == 0) ? int'(out0) : (i == 1) ? int'(out1) : int'(out2);
  endfunction

  function automatic int get_done(input int i);
    return (i == 0) ? int'(done0) : (i == 1) ? int'(done1) : int'(done2);
  endfunction

  function automatic int get_tc(input int i);
    return (i == 0) ? int'(tc0) : (i == 1) ? int'(tc1) : int'(tc2);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: counting rules stated as plain integer arithmetic.
  task automatic model(input int i, input bit c, input bit l, input int lv,
                       input bit e, input bit u, output bit dn);
    int prev = cnt[i];
    int m    = mx(i);
    dn = 1'b0;
    if (c)      cnt[i] = 0;
    else if (l) cnt[i] = (lv > m) ? m : lv;
    else if (e) begin
      if (u) cnt[i] = (cnt[i] < m) ? cnt[i] + 1 : (sat(i) ? m : 0);
      else   cnt[i] = (cnt[i] > 0) ? cnt[i] - 1 : (sat(i) ? 0 : m);
      dn = (cnt[i] == (u ? m : 0)) && (cnt[i] != prev);
    end
  endtask

  task automatic step(input bit c, input bit l, input int lv, input bit e, input bit u);
    exp_t x;
    bit   dn;
    @(posedge clk); #1;
    clr = c; load = l; load_val = 5'(lv); en = e; up_dn = u;
    for (int i = 0; i < 3; i++) begin
      model(i, c, l, lv, e, u, dn);
      x.o[i] = 5'(cnt[i]);
      x.d[i] = dn;
      x.t[i] = u ? (cnt[i] == mx(i)) : (cnt[i] == 0);
    end
    q.push_back(x);
  endtask

  // Monitor: after each falling edge, compare whatever the driver has queued.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk); #2;
      if (q.size() > 0) begin
        x = q.pop_front();
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("out[%0d]", i),  get_out(i),  int'(x.o[i]));
          chk($sformatf("done[%0d]", i), get_done(i), int'(x.d[i]));
          chk($sformatf("tc[%0d]", i),   get_tc(i),   int'(x.t[i]));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_out", get_out(i), 0);
      chk("reset_done", get_done(i), 0);
    end
    @(posedge clk); #3; rst = 1'b1;

    // Count to 17, then assert reset asynchronously mid-cycle.
    repeat (17) step(0, 0, 0, 1, 1);
    @(posedge clk); #3; rst = 1'b0;
    #1;
    chk("async_rst_out", int'(out0), 0);
    chk("async_rst_done", int'(done0), 0);
    repeat (2) begin
      @(negedge clk); #2;
      chk("rst_hold_out", int'(out0), 0);
    end
    @(posedge clk); #3; en = 1'b0; rst = 1'b1;
    for (int i = 0; i < 3; i++) cnt[i] = 0;

    // Up wrap over 33 edges.
    step(1, 0, 0, 0, 1);
    repeat (33) step(0, 0, 0, 1, 1);

    // Load 3 then count down into saturation.
    step(0, 1, 3, 0, 0);
    repeat (5) step(0, 0, 0, 1, 0);

    // Priority clr > load > en, then load beats en.
    step(1, 1, 5, 1, 1);
    step(0, 1, 5, 1, 1);

    // Load clamp.
    step(0, 1, 28, 0, 1);

    // Direction flip at 4, then idle holds.
    step(0, 1, 4, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);

    repeat (400) begin
      step($urandom_range(15) == 0, $urandom_range(7) == 0, int'($urandom_range(31)),
           $urandom_range(3) != 0, 1'($urandom_range(1)));
    end
    step(0, 0, 0, 0, 1);

    @(negedge clk); #4;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
